// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   Initiator side of the core's peripheral path. It decodes load/store
//   requests that fall into the peripheral address region. On a hit it raises
//   cancel_data_memory and runs a single APB3 transfer to the slave chosen by
//   mem_addr[15:12]. The core is stalled until the transfer completes. A
//   transfer completes when the slave is ready or when the ACCESS-cycle
//   timeout expires.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   mem_addr/mem_wdata  core load/store address and store data
//   mem_read/mem_write  core is executing lw / sw (both high = write)
//   cancel_data_memory  request targets the peripheral region (combinational)
//   stall               hold PC and pipeline this cycle (combinational)
//   per_rdata(_valid)   load data for the core's result mux, valid on completion
//   per_err             completing transfer failed (PSLVERR, timeout, bad index)
//   PADDR..PWDATA       registered APB3 master outputs
//   PRDATA/PREADY/PSLVERR  per-slave APB3 return signals
// -----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int unsigned NUM_SLAVES    = 4,
    parameter logic [3:0]  PERIPH_REGION = 4'h4,
    parameter int unsigned ADDR_W        = 12,
    parameter int unsigned TIMEOUT       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wdata,
    input  logic                     mem_read,
    input  logic                     mem_write,
    output logic                     cancel_data_memory,
    output logic                     stall,
    output logic [31:0]              per_rdata,
    output logic                     per_rdata_valid,
    output logic                     per_err,
    output logic [ADDR_W-1:0]        PADDR,
    output logic [NUM_SLAVES-1:0]    PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [31:0]              PWDATA,
    input  logic [32*NUM_SLAVES-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]    PREADY,
    input  logic [NUM_SLAVES-1:0]    PSLVERR
);

    // The counter only has to reach TIMEOUT-1.
    localparam int unsigned    CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit             TO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0]       paddr_q, paddr_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [31:0]             pwdata_q, pwdata_d;

    logic                    hit_s;
    logic [3:0]              idx_s;
    logic                    idx_ok_s;
    logic [NUM_SLAVES-1:0]   psel_onehot_s;
    logic                    rdy_s;
    logic                    slverr_s;
    logic                    timeout_s;
    logic                    done_s;
    logic [31:0]             rdata_sel_s;
    logic                    stall_s;
    logic [31:0]             per_rdata_s;
    logic                    per_rdata_valid_s;
    logic                    per_err_s;

    assign hit_s    = (mem_read | mem_write) & (mem_addr[31:28] == PERIPH_REGION);
    assign idx_s    = mem_addr[15:12];
    assign idx_ok_s = ({28'd0, idx_s} < NUM_SLAVES);

    // The latched PSEL is one-hot during SETUP/ACCESS, so masking with it
    // selects the addressed slave without needing a separate index register.
    assign rdy_s     = |(PREADY & psel_q);
    assign slverr_s  = |(PSLVERR & psel_q);
    assign timeout_s = TO_EN & (cnt_q == CNT_LAST);
    assign done_s    = rdy_s | timeout_s;

    // One-hot decode of the request's slave index.
    always_comb begin
        psel_onehot_s = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            psel_onehot_s[i] = (idx_s == 4'(i));
        end
    end

    // Read-data mux driven by the latched one-hot select.
    always_comb begin
        rdata_sel_s = 32'd0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            rdata_sel_s = rdata_sel_s | (PRDATA[32*i +: 32] & {32{psel_q[i]}});
        end
    end

    // FSM next state, APB register updates and core-facing handshake.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        paddr_d           = paddr_q;
        psel_d            = psel_q;
        penable_d         = penable_q;
        pwrite_d          = pwrite_q;
        pwdata_d          = pwdata_q;
        stall_s           = 1'b0;
        per_rdata_s       = 32'd0;
        per_rdata_valid_s = 1'b0;
        per_err_s         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hit_s) begin
                    if (idx_ok_s) begin
                        paddr_d   = mem_addr[ADDR_W-1:0];
                        pwdata_d  = mem_wdata;
                        pwrite_d  = mem_write;
                        psel_d    = psel_onehot_s;
                        penable_d = 1'b0;
                        state_d   = ST_SETUP;
                        stall_s   = 1'b1;
                    end else begin
                        // No slave behind this index: fail the access at once.
                        per_err_s         = 1'b1;
                        per_rdata_valid_s = ~mem_write;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
                stall_s   = 1'b1;
            end
            ST_ACCESS: begin
                if (done_s) begin
                    // A timed-out transfer reports an error and returns zero data.
                    per_err_s = rdy_s ? slverr_s : 1'b1;
                    if (!pwrite_q) begin
                        per_rdata_valid_s = 1'b1;
                        per_rdata_s       = rdy_s ? rdata_sel_s : 32'd0;
                    end else begin
                        per_rdata_valid_s = 1'b0;
                    end
                    psel_d    = '0;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    stall_s = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                psel_d    = '0;
                penable_d = 1'b0;
                cnt_d     = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and APB output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            paddr_q   <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign cancel_data_memory = hit_s;
    assign stall              = stall_s;
    assign per_rdata          = per_rdata_s;
    assign per_rdata_valid    = per_rdata_valid_s;
    assign per_err            = per_err_s;
    assign PADDR              = paddr_q;
    assign PSEL               = psel_q;
    assign PENABLE            = penable_q;
    assign PWRITE             = pwrite_q;
    assign PWDATA             = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

    localparam int NS     = 4;
    localparam int ADDR_W = 12;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       mem_addr = 32'd0;
    logic [31:0]       mem_wdata = 32'd0;
    logic              mem_read = 1'b0;
    logic              mem_write = 1'b0;
    logic              cancel_data_memory;
    logic              stall;
    logic [31:0]       per_rdata;
    logic              per_rdata_valid;
    logic              per_err;
    logic [ADDR_W-1:0] PADDR;
    logic [NS-1:0]     PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [32*NS-1:0]  PRDATA;
    logic [NS-1:0]     PREADY;
    logic [NS-1:0]     PSLVERR;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave model configuration
    int          tgt = 0;
    int          wait_n = 0;
    logic        serr = 1'b0;
    logic [31:0] tgt_rdata = 32'd0;
    int          acc_cnt = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        e;
        int          st;
    } exp_t;
    exp_t sb[$];

    apb_master_bridge #(
        .NUM_SLAVES(NS), .PERIPH_REGION(4'h4), .ADDR_W(ADDR_W), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .cancel_data_memory(cancel_data_memory), .stall(stall),
        .per_rdata(per_rdata), .per_rdata_valid(per_rdata_valid), .per_err(per_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    // Counts ACCESS cycles seen by the slave model
    always @(posedge clk) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

    // Target slave becomes ready after wait_n ACCESS cycles; other slaves are
    // always ready with an error and junk data, so a wrong select shows up.
    always_comb begin
        PREADY  = '0;
        PSLVERR = '0;
        PRDATA  = '0;
        for (int i = 0; i < NS; i++) begin
            if (i == tgt) begin
                PREADY[i]          = PENABLE && (acc_cnt >= wait_n);
                PSLVERR[i]         = serr;
                PRDATA[32*i +: 32] = tgt_rdata;
            end else begin
                PREADY[i]          = 1'b1;
                PSLVERR[i]         = 1'b1;
                PRDATA[32*i +: 32] = 32'hBAD0_0000 | 32'(i);
            end
        end
    end

    task automatic run_access(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic rd, input logic wr, input int wn, input logic se,
                              input logic [31:0] rdat);
        exp_t e;
        exp_t g;
        logic hit;
        logic [3:0] idx;
        logic ok;
        logic to;
        logic [3:0] oh;
        logic [49:0] apb_exp;
        logic [49:0] apb_got;
        int k;
        int st_cnt;
        bit done;
        hit = (rd | wr) && (addr[31:28] == 4'h4);
        idx = addr[15:12];
        ok  = (idx < 4'd4);
        to  = (wn >= TMO);
        oh  = 4'b0001 << idx;
        if (!hit) begin
            e.v = 1'b0; e.d = 32'd0; e.e = 1'b0; e.st = 0;
        end else if (!ok) begin
            e.v = ~wr; e.d = 32'd0; e.e = 1'b1; e.st = 0;
        end else begin
            e.v  = ~wr;
            e.e  = to ? 1'b1 : se;
            e.d  = (!wr && !to) ? rdat : 32'd0;
            e.st = to ? (TMO + 1) : (2 + wn);
        end
        sb.push_back(e);
        tgt = int'(idx); wait_n = wn; serr = se; tgt_rdata = rdat;
        mem_addr = addr; mem_wdata = wdata; mem_read = rd; mem_write = wr;
        k = 0; st_cnt = 0; done = 0;
        while (!done && k < 64) begin
            @(negedge clk);
            n_tests++;
            if (cancel_data_memory !== hit) begin
                n_fail++;
                $display("FAIL %s cancel k=%0d: got %b want %b", name, k, cancel_data_memory, hit);
            end
            if (hit && ok && k >= 1) begin
                apb_exp = {oh, (k >= 2), addr[11:0], wr, wdata};
                apb_got = {PSEL, PENABLE, PADDR, PWRITE, PWDATA};
                n_tests++;
                if (apb_got !== apb_exp) begin
                    n_fail++;
                    $display("FAIL %s apb k=%0d: got %h want %h", name, k, apb_got, apb_exp);
                end
            end else if (k == 0) begin
                n_tests++;
                if ({PSEL, PENABLE} !== 5'd0) begin
                    n_fail++;
                    $display("FAIL %s apb_idle: got psel=%b pen=%b want 0", name, PSEL, PENABLE);
                end
            end
            if (stall === 1'b1) begin
                n_tests++;
                if ({per_rdata_valid, per_err, per_rdata} !== 34'd0) begin
                    n_fail++;
                    $display("FAIL %s quiet_while_stalled k=%0d: got v=%b e=%b d=%h want 0",
                             name, k, per_rdata_valid, per_err, per_rdata);
                end
                st_cnt++;
            end else begin
                done = 1;
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL %s scoreboard: got empty queue want one entry", name);
                end else begin
                    g = sb.pop_front();
                    n_tests += 4;
                    if (st_cnt !== g.st) begin
                        n_fail++;
                        $display("FAIL %s stall_cycles: got %0d want %0d", name, st_cnt, g.st);
                    end
                    if (per_rdata_valid !== g.v) begin
                        n_fail++;
                        $display("FAIL %s rdata_valid: got %b want %b", name, per_rdata_valid, g.v);
                    end
                    if (per_rdata !== g.d) begin
                        n_fail++;
                        $display("FAIL %s rdata: got %h want %h", name, per_rdata, g.d);
                    end
                    if (per_err !== g.e) begin
                        n_fail++;
                        $display("FAIL %s err: got %b want %b", name, per_err, g.e);
                    end
                end
            end
            @(posedge clk); #1;
            k++;
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL %s completion_timeout: got no completion in %0d cycles want %0d stall cycles",
                     name, k, e.st);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({PSEL, PENABLE, stall, per_rdata_valid, per_err} !== 9'd0) begin
            n_fail++;
            $display("FAIL %s back_to_idle: got psel=%b pen=%b stall=%b v=%b e=%b want all 0",
                     name, PSEL, PENABLE, stall, per_rdata_valid, per_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, stall, per_rdata_valid, per_err,
             per_rdata, cancel_data_memory} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got psel=%b pen=%b paddr=%h pw=%b pwd=%h stall=%b v=%b e=%b d=%h c=%b want all 0",
                     PSEL, PENABLE, PADDR, PWRITE, PWDATA, stall, per_rdata_valid, per_err,
                     per_rdata, cancel_data_memory);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write_basic();
        run_access("sw_slave1", 32'h4000_1008, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, 1'b0, 32'h0);
    endtask

    task automatic test_read_wait();
        run_access("lw_slave2_wait3", 32'h4000_2004, 32'h0, 1'b1, 1'b0, 3, 1'b0, 32'h1234_5678);
    endtask

    task automatic test_timeout();
        run_access("lw_timeout", 32'h4000_0000, 32'h0, 1'b1, 1'b0, 1000, 1'b0, 32'hCAFE_F00D);
        run_access("lw_ready_last", 32'h4000_0040, 32'h0, 1'b1, 1'b0, 15, 1'b0, 32'h0F0F_0F0F);
    endtask

    task automatic test_bad_index();
        run_access("sw_bad_idx", 32'h4000_7000, 32'h1111_2222, 1'b0, 1'b1, 0, 1'b0, 32'h0);
        run_access("lw_bad_idx", 32'h4000_F010, 32'h0, 1'b1, 1'b0, 0, 1'b0, 32'h0);
    endtask

    task automatic test_non_hit();
        run_access("lw_nonhit", 32'h0000_0010, 32'h0, 1'b1, 1'b0, 0, 1'b0, 32'h5555_5555);
        run_access("sw_nonhit", 32'h8000_1000, 32'h7777_7777, 1'b0, 1'b1, 0, 1'b0, 32'h0);
    endtask

    task automatic test_slverr();
        run_access("sw_slverr", 32'h4000_3FFC, 32'h0BAD_0BAD, 1'b0, 1'b1, 1, 1'b1, 32'h0);
        run_access("lw_slverr", 32'h4000_1ABC, 32'h0, 1'b1, 1'b0, 2, 1'b1, 32'hA5A5_5A5A);
    endtask

    task automatic test_rd_wr_both();
        run_access("rd_wr_both", 32'h4000_0ABC, 32'h1357_9BDF, 1'b1, 1'b1, 0, 1'b0, 32'h2468_ACE0);
    endtask

    task automatic test_reset_mid();
        tgt = 0; wait_n = 1000; serr = 1'b0; tgt_rdata = 32'h0;
        mem_addr = 32'h4000_0100; mem_read = 1'b1; mem_write = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        n_tests++;
        if ({PSEL, PENABLE, stall} !== 6'b0001_1_1) begin
            n_fail++;
            $display("FAIL reset_mid_in_access: got psel=%b pen=%b stall=%b want 0001 1 1",
                     PSEL, PENABLE, stall);
        end
        @(posedge clk); #1;
        rst = 1'b1; mem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({PSEL, PENABLE, stall, per_rdata_valid, per_err} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_mid_drop: got psel=%b pen=%b stall=%b v=%b e=%b want all 0",
                     PSEL, PENABLE, stall, per_rdata_valid, per_err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_access("after_reset", 32'h4000_2010, 32'h0, 1'b1, 1'b0, 1, 1'b0, 32'h8765_4321);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 10; n++) begin
            logic [31:0] a;
            int op;
            int wn;
            a        = $urandom;
            a[31:28] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'h4;
            a[15:12] = 4'($urandom_range(0, 5));
            op       = $urandom_range(0, 2);
            wn       = ($urandom_range(0, 4) == 0) ? 20 : $urandom_range(0, 5);
            run_access("random", a, $urandom, (op != 1), (op != 0), wn,
                       1'($urandom_range(0, 1)), $urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_timeout();
        test_bad_index();
        test_non_hit();
        test_slverr();
        test_rd_wr_both();
        test_reset_mid();
        test_back_to_back();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
